// File: rtl/sb_lane_alu_pkg.sv
// Shared types for the stream lane ALU: operation encoding, captured per-packet
// configuration and the single-lane operation used by the datapath.
package sb_lane_alu_pkg;

  localparam int unsigned LW_MAX     = 64;
  localparam int unsigned LANES_MAX  = 64;
  localparam int unsigned LANE_IDX_W = $clog2(LANES_MAX);

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_XOR  = 2'd3
  } op_e;

  // Sized for the widest supported lane/lane-count; narrower builds zero-fill.
  typedef struct packed {
    op_e                  op;
    logic [LW_MAX-1:0]    operand;
    logic [LANES_MAX-1:0] mask;
  } cfg_t;

  function automatic logic [LW_MAX-1:0] lane_op(input cfg_t                  cfg,
                                                input logic [LANE_IDX_W-1:0] lane,
                                                input logic [LW_MAX-1:0]     a);
    logic [LW_MAX-1:0] r;
    r = a;
    if (cfg.mask[lane]) begin
      case (cfg.op)
        OP_ADD:  r = a + cfg.operand;
        OP_SUB:  r = a - cfg.operand;
        OP_XOR:  r = a ^ cfg.operand;
        default: r = a;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/sb_skid_buf.sv
// Generic two-register skid buffer (output register plus one skid register);
// in_ready is a pure register so no combinational path crosses the buffer.
module sb_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [W-1:0] in_payload,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_payload,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] skid_payload;
  logic         skid_valid;
  logic         accept;

  assign accept   = in_valid & in_ready;
  assign in_ready = ~skid_valid;

  // Output slot frees up when empty or draining; skid contents take priority
  // (no accept can be pending while the skid is full).
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_payload  <= '0;
      out_valid    <= 1'b0;
      skid_payload <= '0;
      skid_valid   <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_payload <= skid_payload;
        out_valid   <= 1'b1;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_payload <= in_payload;
        out_valid   <= 1'b1;
      end else begin
        out_valid   <= 1'b0;
      end
    end else if (accept) begin
      skid_payload <= in_payload;
      skid_valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/sb_stream_lane_alu.sv
// Per-lane runtime ALU on a switchboard stream with per-packet config capture.
// Optional statistics counters are built when SB_LANE_ALU_STATS_EN is defined.
module sb_stream_lane_alu
  import sb_lane_alu_pkg::*;
#(
  parameter int unsigned DW    = 256,
  parameter int unsigned LW    = 64,
  parameter int unsigned DESTW = 32,
  localparam int unsigned LANES = DW / LW
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [1:0]       cfg_op,
  input  logic [LW-1:0]    cfg_operand,
  input  logic [LANES-1:0] cfg_lane_mask,
  input  logic [DW-1:0]    in_data,
  input  logic [DESTW-1:0] in_dest,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DW-1:0]    out_data,
  output logic [DESTW-1:0] out_dest,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done
`ifdef SB_LANE_ALU_STATS_EN
  ,
  output logic [31:0]      stat_beats,
  output logic [31:0]      stat_pkts
`endif
);

  localparam int unsigned PW = DW + DESTW + 1;

  logic              accept;
  logic              sop;
  cfg_t              cfg_new;
  cfg_t              cfg_q;
  cfg_t              cfg_eff;
  logic [DW-1:0]     xdata;
  logic [LW_MAX-1:0] lane_in;
  logic [LW_MAX-1:0] lane_out;
  logic [PW-1:0]     out_payload;

  assign accept = in_valid & in_ready;

  always_comb begin
    cfg_new                  = '0;
    cfg_new.op               = op_e'(cfg_op);
    cfg_new.operand[LW-1:0]  = cfg_operand;
    cfg_new.mask[LANES-1:0]  = cfg_lane_mask;
  end

  // First beat of a packet sees the live config; later beats the captured copy.
  assign cfg_eff = sop ? cfg_new : cfg_q;

  always_comb begin
    xdata    = in_data;
    lane_in  = '0;
    lane_out = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_in           = '0;
      lane_in[LW-1:0]   = in_data[i*LW +: LW];
      lane_out          = lane_op(cfg_eff, LANE_IDX_W'(i), lane_in);
      xdata[i*LW +: LW] = lane_out[LW-1:0];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sop   <= 1'b1;
      cfg_q <= '0;
      done  <= 1'b0;
    end else if (accept) begin
      sop <= in_last;
      if (sop) begin
        cfg_q <= cfg_new;
      end
      if (&in_data) begin
        done <= 1'b1;
      end
    end
  end

  sb_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk         (clk),
    .nreset      (nreset),
    .in_payload  ({xdata, in_dest, in_last}),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_payload (out_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  assign {out_data, out_dest, out_last} = out_payload;

`ifdef SB_LANE_ALU_STATS_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stat_beats <= '0;
      stat_pkts  <= '0;
    end else if (accept) begin
      stat_beats <= stat_beats + 32'd1;
      if (in_last) begin
        stat_pkts <= stat_pkts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sb_stream_lane_alu.sv
// Scoreboard bench for sb_stream_lane_alu (DW=256, LW=64): expected beats are
// queued at accept time and compared as they leave the output port.
module tb_sb_stream_lane_alu;

  logic         clk = 1'b0;
  logic         nreset;
  logic [1:0]   cfg_op;
  logic [63:0]  cfg_operand;
  logic [3:0]   cfg_lane_mask;
  logic [255:0] in_data;
  logic [31:0]  in_dest;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] out_data;
  logic [31:0]  out_dest;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic         done;
`ifdef SB_LANE_ALU_STATS_EN
  logic [31:0]  stat_beats;
  logic [31:0]  stat_pkts;
`endif

  sb_stream_lane_alu #(
    .DW    (256),
    .LW    (64),
    .DESTW (32)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .cfg_op        (cfg_op),
    .cfg_operand   (cfg_operand),
    .cfg_lane_mask (cfg_lane_mask),
    .in_data       (in_data),
    .in_dest       (in_dest),
    .in_last       (in_last),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_dest      (out_dest),
    .out_last      (out_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .done          (done)
`ifdef SB_LANE_ALU_STATS_EN
    ,
    .stat_beats    (stat_beats),
    .stat_pkts     (stat_pkts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  dest;
    logic         last;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic        m_sop = 1'b1;
  logic [1:0]  m_op;
  logic [63:0] m_k;
  logic [3:0]  m_m;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model(input logic [255:0] d, input logic [1:0] op,
                                         input logic [63:0] k, input logic [3:0] m);
    logic [255:0] r;
    logic [63:0]  v;
    r = d;
    for (int i = 0; i < 4; i++) begin
      v = d[i*64 +: 64];
      if (m[i]) begin
        case (op)
          2'd1:    v = v + k;
          2'd2:    v = v - k;
          2'd3:    v = v ^ k;
          default: v = v;
        endcase
      end
      r[i*64 +: 64] = v;
    end
    return r;
  endfunction

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic send(input logic [255:0] d, input logic [31:0] dst, input logic lst);
    int unsigned waited = 0;
    bit          ok     = 1'b0;
    in_data  = d;
    in_dest  = dst;
    in_last  = lst;
    in_valid = 1'b1;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        if (m_sop) begin
          m_op = cfg_op;
          m_k  = cfg_operand;
          m_m  = cfg_lane_mask;
        end
        sb.push_back('{model(d, m_op, m_k, m_m), dst, lst});
        m_sop = lst;
      end else begin
        waited++;
      end
    end
    if (!ok) check("accept_timeout", 256'(in_ready), 256'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain", 256'(sb.size()), 256'd0);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] op, input logic [63:0] k, input logic [3:0] m);
    cfg_op        = op;
    cfg_operand   = k;
    cfg_lane_mask = m;
  endtask

  always @(negedge clk) begin
    if (nreset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 256'(out_valid), 256'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", out_data, e.d);
        check("out_dest", 256'(out_dest), 256'(e.dest));
        check("out_last", 256'(out_last), 256'(e.last));
      end
    end
  end

  logic [255:0] ones;

  initial begin
    ones      = '1;
    nreset    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dest   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    set_cfg(2'd0, 64'd0, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 256'(out_valid), 256'd0);
    check("rst_in_ready", 256'(in_ready), 256'd1);
    check("rst_done", 256'(done), 256'd0);
    check("rst_out_data", out_data, 256'd0);
    nreset = 1'b1;
    @(posedge clk);
    #1;

    // add 42 on lane 0 only, single-beat packet
    set_cfg(2'd1, 64'd42, 4'b0001);
    send({64'd7, 64'd7, 64'd7, 64'd5}, 32'hA001, 1'b1);
    check("t1_latency_valid", 256'(out_valid), 256'd1);
    check("t1_in_ready", 256'(in_ready), 256'd1);
    check("t1_lane0", 256'(out_data[63:0]), 256'd47);
    check("t1_lane3", 256'(out_data[255:192]), 256'd7);

    // sub 1 on all lanes of zero, then add 1 wraps lane 0 only
    set_cfg(2'd2, 64'd1, 4'b1111);
    send(256'd0, 32'hA002, 1'b1);
    check("t2_sub_wrap", out_data, {4{64'hFFFF_FFFF_FFFF_FFFF}});
    set_cfg(2'd1, 64'd1, 4'b0001);
    send({64'd3, 64'd3, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF}, 32'hA003, 1'b1);
    check("t2_add_wrap", 256'(out_data[63:0]), 256'd0);
    check("t2_no_carry", 256'(out_data[127:64]), 256'd3);

    // config change mid-packet is ignored until the next packet
    set_cfg(2'd1, 64'd1, 4'b1111);
    send({4{64'h10}}, 32'hB000, 1'b0);
    set_cfg(2'd3, 64'hFF, 4'b1111);
    send({4{64'h20}}, 32'hB001, 1'b0);
    send({4{64'h10}}, 32'hB002, 1'b1);
    check("t3_last_uses_add", 256'(out_data[63:0]), 256'h11);
    send({4{64'h10}}, 32'hB003, 1'b1);
    check("t3_next_uses_xor", 256'(out_data[63:0]), 256'hEF);

    // backpressure burst: output + skid hold two beats, in_ready drops
    set_cfg(2'd1, 64'd5, 4'b1010);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send({4{64'(i + 100)}}, 32'(32'hC000 + i), (i == 5));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check("t4_in_ready_low", 256'(in_ready), 256'd0);
        check("t4_held_beats", 256'(sb.size()), 256'd2);
        out_ready = 1'b1;
      end
    join
    drain();

    // all-ones beat sets sticky done and is forwarded unchanged
    check("t5_done_before", 256'(done), 256'd0);
    set_cfg(2'd0, 64'd0, 4'b1111);
    send(ones, 32'hD000, 1'b1);
    check("t5_done_set", 256'(done), 256'd1);
    check("t5_data_fwd", out_data, ones);
    send(256'h1234, 32'hD001, 1'b1);
    check("t5_done_sticky", 256'(done), 256'd1);
    drain();

    // reset mid-packet discards the held beat and restores sop
    out_ready = 1'b0;
    set_cfg(2'd1, 64'd3, 4'b1111);
    send({4{64'h40}}, 32'hE000, 1'b0);
    nreset = 1'b0;
    #1;
    check("t6_rst_out_valid", 256'(out_valid), 256'd0);
    check("t6_rst_done", 256'(done), 256'd0);
    check("t6_rst_in_ready", 256'(in_ready), 256'd1);
    sb.delete();
    m_sop = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nreset    = 1'b1;
    out_ready = 1'b1;
    set_cfg(2'd3, 64'hF0, 4'b0001);
    send({4{64'h0F}}, 32'hE001, 1'b1);
    check("t6_sop_restored", 256'(out_data[63:0]), 256'hFF);
    drain();

`ifdef SB_LANE_ALU_STATS_EN
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    m_sop  = 1'b1;
    nreset = 1'b1;
    set_cfg(2'd1, 64'd1, 4'b1111);
    for (int p = 0; p < 5; p++) begin
      send({4{64'(p)}}, 32'(p), 1'b0);
      send({4{64'(p + 8)}}, 32'(p), 1'b1);
    end
    drain();
    check("stat_beats", 256'(stat_beats), 256'd10);
    check("stat_pkts", 256'(stat_pkts), 256'd5);
    nreset = 1'b0;
    #1;
    check("stat_beats_rst", 256'(stat_beats), 256'd0);
    check("stat_pkts_rst", 256'(stat_pkts), 256'd0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
`endif

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
